tnnseq_frame_driver: RTL and testbench
======================================

# tnnseq_frame_driver

Host-side driver for the sequential ternary-network engines (`*_tnn1_tnnseq`). It receives one sample as a stream of FEAT_BITS-wide features over a valid/ready handshake and assembles the parallel feature word the engine expects. It then pulses the engine reset, waits the engine's fixed latency, captures the class index and returns it on a valid/ready result port. It takes over, in silicon, the role the simulation bench plays around the engine.

## Interface
- FEAT_CNT, 128, features per sample
- FEAT_BITS, 4, bits per feature
- HIDDEN_CNT, 40, hidden neurons in the engine
- CLASS_CNT, 6, classes; CLS_W = $clog2(CLASS_CNT)
- ENGINE_LAT, FEAT_CNT+HIDDEN_CNT, engine cycles from reset release to valid prediction
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- s_valid  in  1  feature beat valid
- s_ready  out  1  driver accepts feature beat
- s_feat  in  FEAT_BITS  feature value
- eng_data  out  FEAT_BITS*FEAT_CNT  parallel feature word to engine `data`
- eng_rst  out  1  engine reset, active-high
- eng_pred  in  CLS_W  engine `prediction`
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_class  out  CLS_W  captured class index
- busy  out  1  high in START, RUN, HOLD
- frame_cnt  out  16  results delivered, wraps at 2^16

## Operation
- FSM states: LOAD, START, RUN, HOLD. Reset state is LOAD.
- LOAD
  - s_ready=1.
  - Each beat with s_valid&&s_ready writes s_feat to eng_data[k*FEAT_BITS +: FEAT_BITS], where k = beat index 0..FEAT_CNT-1. Beat 0 lands in the LSBs.
  - The beat counter increments per beat. The beat with k=FEAT_CNT-1 moves the FSM to START and clears the counter.
- START: lasts exactly 1 cycle, s_ready=0, then RUN. The cycle counter is cleared.
- RUN
  - Lasts exactly ENGINE_LAT cycles; the cycle counter counts 0..ENGINE_LAT-1.
  - On the edge ending the cycle with counter==ENGINE_LAT-1: m_class<=eng_pred, m_valid<=1, state<=HOLD.
- HOLD
  - m_valid=1; m_class is held stable.
  - On m_valid&&m_ready: m_valid<=0, frame_cnt<=frame_cnt+1, state<=LOAD.
- eng_rst = (state != RUN). The engine is held in reset everywhere except RUN.
- eng_data changes only in LOAD. It is stable through START and RUN.
- eng_pred is sampled only at the capture edge and ignored otherwise.
- s_valid outside LOAD is ignored; no beat is consumed.
- Counter widths:
  - Beat counter: $clog2(FEAT_CNT).
  - Cycle counter: $clog2(ENGINE_LAT).
  - Neither counter wraps during normal operation. Terminal compares are on equality.

## Timing
- Reset values (rst==0 at a rising edge):
  - State LOAD; beat and cycle counters 0.
  - eng_data 0, m_valid 0, m_class 0, frame_cnt 0.
  - eng_rst 1, s_ready 1, busy 0.
- Reset mid-frame in any state aborts the frame. A partial load is discarded, and a pending result is dropped without incrementing frame_cnt.
- Frame latency:
  - Last feature beat accepted at edge E. START occupies the cycle after E.
  - eng_rst is low for exactly ENGINE_LAT cycles.
  - m_valid rises at edge E+1+ENGINE_LAT.
- Minimum frame period is FEAT_CNT+ENGINE_LAT+2 cycles (back-to-back s_valid, m_ready held high).
- m_ready high when m_valid rises: the handshake completes in the first HOLD cycle, and s_ready is 1 the next cycle.
- Backpressure: m_ready low holds HOLD indefinitely with s_ready=0. No second frame is accepted while a result is pending.
- frame_cnt 16'hFFFF followed by a delivered result gives 16'h0000.

## Test plan
- Basic load (FEAT_CNT=4, FEAT_BITS=4, HIDDEN_CNT=3, ENGINE_LAT=7): beats 1,2,3,4 with continuous s_valid -> eng_data=16'h4321; eng_rst low for exactly 7 cycles; m_valid rises 8 edges after the beat-4 edge; m_class equals the eng_pred driven on the last RUN cycle (e.g. 3).
- Gapped input: same beats with s_valid low on alternate cycles -> same eng_data 16'h4321; s_valid during RUN/HOLD is not consumed and eng_data is unchanged.
- Result backpressure: m_ready low for 20 cycles after m_valid -> m_valid and m_class stable, s_ready=0, frame_cnt unchanged; m_ready high -> one handshake, frame_cnt +1, s_ready=1 next cycle.
- Reset mid-RUN: rst low at RUN cycle 3 -> next cycle state LOAD, eng_rst=1, m_valid=0, eng_data=0, frame_cnt unchanged; a following full frame completes normally.
- Back-to-back with m_ready tied high: 3 frames -> 3 results, each period FEAT_CNT+ENGINE_LAT+2 cycles, frame_cnt=3; eng_pred glitching outside the capture cycle does not affect m_class.
- Full engine integration (default parameters, gasId engine): 1000 samples from gasId.memh -> m_class sequence identical to the engine-level bench output.

Source files
------------

// File: rtl/tnnseq_frame_driver_if.sv
// Feature-stream and result-stream handshakes between the host side and the frame driver.
interface tnnseq_frame_driver_if #(
  parameter int unsigned FeatBits = 4,
  parameter int unsigned ClsW     = 3
) ();
  logic                s_valid;
  logic                s_ready;
  logic [FeatBits-1:0] s_feat;
  logic                m_valid;
  logic                m_ready;
  logic [ClsW-1:0]     m_class;

  modport slave (
    input  s_valid, s_feat, m_ready,
    output s_ready, m_valid, m_class
  );

  modport master (
    output s_valid, s_feat, m_ready,
    input  s_ready, m_valid, m_class
  );
endinterface

// File: rtl/tnnseq_frame_driver.sv
// Collects one sample of streamed features, runs the sequential ternary engine for its fixed
// latency and hands back the captured class index over a valid/ready port.
module tnnseq_frame_driver #(
  parameter int unsigned FeatCnt   = 128,
  parameter int unsigned FeatBits  = 4,
  parameter int unsigned HiddenCnt = 40,
  parameter int unsigned ClassCnt  = 6,
  parameter int unsigned ClsW      = $clog2(ClassCnt),
  parameter int unsigned EngineLat = FeatCnt + HiddenCnt
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  tnnseq_frame_driver_if.slave        bus,
  output logic [FeatCnt*FeatBits-1:0] eng_data_o,
  output logic                        eng_rst_o,
  input  logic [ClsW-1:0]             eng_pred_i,
  output logic                        busy_o,
  output logic [15:0]                 frame_cnt_o
);
  localparam int unsigned BeatW = (FeatCnt > 1) ? $clog2(FeatCnt) : 1;
  localparam int unsigned CycW  = (EngineLat > 1) ? $clog2(EngineLat) : 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(FeatCnt - 1);
  localparam logic [CycW-1:0]  CycLast  = CycW'(EngineLat - 1);

  localparam logic [1:0] StLoad  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [BeatW-1:0]            beat_q, beat_d;
  logic [CycW-1:0]             cyc_q, cyc_d;
  logic [FeatCnt*FeatBits-1:0] data_q, data_d;
  logic                        m_valid_q, m_valid_d;
  logic [ClsW-1:0]             cls_q, cls_d;
  logic [15:0]                 fcnt_q, fcnt_d;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cyc_d     = cyc_q;
    data_d    = data_q;
    m_valid_d = m_valid_q;
    cls_d     = cls_q;
    fcnt_d    = fcnt_q;
    case (state_q)
      StLoad: begin
        if (bus.s_valid) begin
          data_d[int'(beat_q) * FeatBits +: FeatBits] = bus.s_feat;
          if (beat_q == BeatLast) begin
            beat_d  = '0;
            state_d = StStart;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StStart: begin
        cyc_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        // The prediction is only meaningful on the final engine cycle.
        if (cyc_q == CycLast) begin
          cls_d     = eng_pred_i;
          m_valid_d = 1'b1;
          cyc_d     = '0;
          state_d   = StHold;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StHold: begin
        if (m_valid_q && bus.m_ready) begin
          m_valid_d = 1'b0;
          fcnt_d    = fcnt_q + 16'd1;
          state_d   = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StLoad;
      beat_q    <= '0;
      cyc_q     <= '0;
      data_q    <= '0;
      m_valid_q <= 1'b0;
      cls_q     <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cyc_q     <= cyc_d;
      data_q    <= data_d;
      m_valid_q <= m_valid_d;
      cls_q     <= cls_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign bus.s_ready  = (state_q == StLoad);
  assign bus.m_valid  = m_valid_q;
  assign bus.m_class  = cls_q;
  assign eng_data_o   = data_q;
  assign eng_rst_o    = (state_q != StRun);
  assign busy_o       = (state_q != StLoad);
  assign frame_cnt_o  = fcnt_q;
endmodule

// File: tb/tb_tnnseq_frame_driver.sv
// Self-checking bench for tnnseq_frame_driver: vector table, reset corner cases and random frames.
module tb_tnnseq_frame_driver;
  localparam int F = 4;
  localparam int B = 4;
  localparam int H = 3;
  localparam int C = 6;
  localparam int W = 3;
  localparam int L = F + H;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tnnseq_frame_driver_if #(.FeatBits(B), .ClsW(W)) bus ();

  logic [F*B-1:0] eng_data;
  logic           eng_rst;
  logic [W-1:0]   eng_pred;
  logic           busy;
  logic [15:0]    frame_cnt;

  tnnseq_frame_driver #(
    .FeatCnt(F), .FeatBits(B), .HiddenCnt(H), .ClassCnt(C)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .eng_data_o  (eng_data),
    .eng_rst_o   (eng_rst),
    .eng_pred_i  (eng_pred),
    .busy_o      (busy),
    .frame_cnt_o (frame_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_fc;

  typedef struct {
    logic [F-1:0][B-1:0] beats;
    bit                  gapped;
    bit                  junk;
    logic [W-1:0]        pred;
    int                  hold;
    logic [F*B-1:0]      exp_data;
    logic [W-1:0]        exp_cls;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2,
                              input logic [3:0] b3, input bit gp, input bit jk,
                              input logic [2:0] p, input int hd, input logic [15:0] ed);
    vec_t v;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
    v.gapped = gp; v.junk = jk; v.pred = p; v.hold = hd;
    v.exp_data = ed; v.exp_cls = p;
    return v;
  endfunction

  // Reference: beat k occupies nibble k of the engine word.
  function automatic logic [F*B-1:0] model_data(input logic [F-1:0][B-1:0] beats);
    logic [F*B-1:0] acc = '0;
    for (int k = 0; k < F; k++) acc = acc | ((F*B)'(beats[k]) << (B * k));
    return acc;
  endfunction

  task automatic do_frame(input vec_t v, input string nm);
    int k = 0, t = 0, lowcnt = 0, drift = 0, total = 0, rise = -1, hold_bad = 0;
    bus.m_ready = (v.hold == 0);
    while (k < F && t < 4 * F) begin
      bus.s_valid = !(v.gapped && (t % 2 == 1));
      bus.s_feat  = bus.s_valid ? v.beats[k] : 4'($urandom);
      @(negedge clk); total++;
      if (bus.s_valid) k++;
      t++;
    end
    bus.s_valid = 1'b0;
    chk({nm, ":data"}, eng_data, v.exp_data);
    chk({nm, ":start"}, {bus.s_ready, busy, eng_rst}, 3'b011);
    for (int c = 0; c <= L + 4; c++) begin
      if (v.junk) begin
        bus.s_valid = 1'b1;
        bus.s_feat  = 4'($urandom);
      end
      eng_pred = (c == L) ? v.pred : W'((int'(v.pred) + 1 + $urandom_range(0, C - 2)) % C);
      @(negedge clk); total++;
      if (!eng_rst) lowcnt++;
      if (eng_data !== v.exp_data) drift++;
      if (bus.m_valid === 1'b1) begin
        rise = c;
        break;
      end
    end
    bus.s_valid = 1'b0;
    chk({nm, ":latency"}, 64'(rise), 64'(L));
    if (rise < 0) begin
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; exp_fc = '0;
      return;
    end
    chk({nm, ":rst_low"}, 64'(lowcnt), 64'(L));
    chk({nm, ":data_stable"}, 64'(drift), 64'd0);
    chk({nm, ":class"}, bus.m_class, v.exp_cls);
    chk({nm, ":hold_rdy"}, {bus.s_ready, busy, eng_rst}, 3'b011);
    for (int h = 0; h < v.hold; h++) begin
      eng_pred = W'($urandom_range(0, C - 1));
      bus.s_valid = v.junk;
      @(negedge clk);
      if (bus.m_valid !== 1'b1 || bus.m_class !== v.exp_cls || bus.s_ready !== 1'b0 ||
          frame_cnt !== exp_fc) hold_bad++;
    end
    bus.s_valid = 1'b0;
    if (v.hold > 0) chk({nm, ":backpressure"}, 64'(hold_bad), 64'd0);
    bus.m_ready = 1'b1;
    @(negedge clk); total++;
    exp_fc = exp_fc + 16'd1;
    chk({nm, ":done"}, {bus.m_valid, bus.s_ready, busy, eng_rst}, 4'b0101);
    chk({nm, ":frame_cnt"}, frame_cnt, exp_fc);
    chk({nm, ":data_kept"}, eng_data, v.exp_data);
    if (!v.gapped && v.hold == 0) chk({nm, ":period"}, 64'(total), 64'(F + L + 2));
    bus.m_ready = 1'b0;
  endtask

  initial begin
    vec_t rv;
    rst_n = 1'b0;
    bus.s_valid = 1'b0; bus.s_feat = '0; bus.m_ready = 1'b0;
    eng_pred = '0;
    exp_fc = '0;
    @(negedge clk); @(negedge clk);
    chk("reset_data", eng_data, 16'h0000);
    chk("reset_flags", {eng_rst, bus.s_ready, busy, bus.m_valid}, 4'b1100);
    chk("reset_class", bus.m_class, 3'd0);
    chk("reset_fcnt", frame_cnt, 16'd0);
    rst_n = 1'b1;

    // Partial load, then reset: the beat index must restart at zero.
    bus.s_valid = 1'b1; bus.s_feat = 4'hA; @(negedge clk);
    bus.s_feat = 4'hB; @(negedge clk);
    bus.s_valid = 1'b0;
    chk("partial_data", eng_data, 16'h00BA);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    chk("partial_reset", eng_data, 16'h0000);

    // Full load, reset on RUN cycle 3.
    for (int k = 0; k < F; k++) begin
      bus.s_valid = 1'b1; bus.s_feat = 4'(k + 5); @(negedge clk);
    end
    bus.s_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      eng_pred = W'($urandom_range(0, C - 1)); @(negedge clk);
    end
    chk("midrun_in_run", {eng_rst, busy}, 2'b01);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    chk("midrun_flags", {eng_rst, bus.m_valid, bus.s_ready, busy}, 4'b1010);
    chk("midrun_data", eng_data, 16'h0000);
    chk("midrun_fcnt", frame_cnt, exp_fc);

    vecs[0] = mk(4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 1'b0, 3'd3, 0, 16'h4321);
    vecs[1] = mk(4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b1, 3'd5, 0, 16'h4321);
    vecs[2] = mk(4'h9, 4'h0, 4'hF, 4'h6, 1'b0, 1'b1, 3'd2, 20, 16'h6F09);
    vecs[3] = mk(4'hC, 4'hD, 4'hE, 4'hF, 1'b0, 1'b0, 3'd0, 0, 16'hFEDC);
    vecs[4] = mk(4'h7, 4'h7, 4'h0, 4'h1, 1'b0, 1'b0, 3'd1, 0, 16'h1077);
    vecs[5] = mk(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 3'd4, 0, 16'hFFFF);
    for (int i = 0; i < 6; i++) do_frame(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < F; k++) rv.beats[k] = 4'($urandom);
      rv.gapped   = 1'($urandom);
      rv.junk     = 1'($urandom);
      rv.pred     = W'($urandom_range(0, C - 1));
      rv.hold     = $urandom_range(0, 3);
      rv.exp_data = model_data(rv.beats);
      rv.exp_cls  = rv.pred;
      do_frame(rv, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
